// File: rtl/vm_pkg.sv
// Shared vending-machine constants and the change-payout FSM state encoding.
package vm_pkg;

  localparam int UNIT_5  = 1;
  localparam int UNIT_10 = 2;

  localparam int PRICE_1 = 3;
  localparam int PRICE_2 = 5;

  typedef enum logic [2:0] {
    PAY_IDLE,
    PAY_SELECT,
    PAY_EJECT,
    PAY_GAP,
    PAY_DONE
  } pay_state_t;

endpackage

// File: rtl/vm_tube_counter.sv
// Coin tube occupancy: saturating up/down counter with empty/full flags.
module vm_tube_counter #(
  parameter int CNT_W    = 4,
  parameter int TUBE_MAX = 15,
  parameter int INIT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  // Simultaneous coin-in and eject cancel, which also keeps a full tube full.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic inc_i,
                                                input logic dec_i);
    logic [CNT_W-1:0] r;
    r = c;
    case ({inc_i, dec_i})
      2'b10:   r = (c == CNT_W'(TUBE_MAX)) ? c : c + 1'b1;
      2'b01:   r = (c == '0) ? c : c - 1'b1;
      default: r = c;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) count <= CNT_W'(INIT);
    else       count <= sat_step(count, inc, dec);
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(TUBE_MAX));

endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy change payout from the 5 and 10 coin tubes with actuator recovery spacing.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W     = 4,
  parameter int CNT_W     = 4,
  parameter int TUBE_MAX  = 15,
  parameter int INIT_5    = 4,
  parameter int INIT_10   = 4,
  parameter int PULSE_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_5_in,
  input  logic             coin_10_in,
  input  logic             pay_req,
  input  logic [AMT_W-1:0] pay_amt,
  output logic             pay_ack,
  output logic             pay_done,
  output logic             pay_short,
  output logic [AMT_W-1:0] pay_rem,
  output logic             change_5,
  output logic             change_10,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic             exact_only,
  output logic             busy
);

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

  pay_state_t       state, state_nx;
  logic [AMT_W-1:0] rem, rem_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             sel_10, sel_nx;
  logic             ack_nx, done_nx, short_nx, c5_nx, c10_nx, busy_nx;
  logic [AMT_W-1:0] pay_rem_nx;
  logic             empty_5, empty_10, full_5, full_10;

  // The eject pulse itself drives the decrement, so a coin landing in the
  // same cycle nets out inside the counter.
  vm_tube_counter #(.CNT_W(CNT_W), .TUBE_MAX(TUBE_MAX), .INIT(INIT_5)) u_tube_5 (
    .clk   (clk),
    .reset (reset),
    .inc   (coin_5_in),
    .dec   (change_5),
    .count (cnt_5),
    .empty (empty_5),
    .full  (full_5)
  );

  vm_tube_counter #(.CNT_W(CNT_W), .TUBE_MAX(TUBE_MAX), .INIT(INIT_10)) u_tube_10 (
    .clk   (clk),
    .reset (reset),
    .inc   (coin_10_in),
    .dec   (change_10),
    .count (cnt_10),
    .empty (empty_10),
    .full  (full_10)
  );

  assign exact_only = empty_5;

  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    gap_nx     = gap_cnt;
    sel_nx     = sel_10;
    ack_nx     = 1'b0;
    done_nx    = 1'b0;
    short_nx   = 1'b0;
    pay_rem_nx = '0;
    c5_nx      = 1'b0;
    c10_nx     = 1'b0;
    busy_nx    = busy;
    case (state)
      PAY_IDLE: begin
        busy_nx = 1'b0;
        if (pay_req) begin
          rem_nx   = pay_amt;
          state_nx = PAY_SELECT;
          ack_nx   = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      PAY_SELECT: begin
        if (rem >= AMT_W'(UNIT_10) && !empty_10) begin
          sel_nx   = 1'b1;
          rem_nx   = rem - AMT_W'(UNIT_10);
          state_nx = PAY_EJECT;
        end else if (rem >= AMT_W'(UNIT_5) && !empty_5) begin
          sel_nx   = 1'b0;
          rem_nx   = rem - AMT_W'(UNIT_5);
          state_nx = PAY_EJECT;
        end else begin
          state_nx   = PAY_DONE;
          done_nx    = 1'b1;
          short_nx   = (rem != '0);
          pay_rem_nx = rem;
        end
      end
      PAY_EJECT: begin
        c10_nx   = sel_10;
        c5_nx    = ~sel_10;
        gap_nx   = GAP_W'(PULSE_GAP - 1);
        state_nx = PAY_GAP;
      end
      PAY_GAP: begin
        if (gap_cnt == '0) state_nx = PAY_SELECT;
        else               gap_nx   = gap_cnt - 1'b1;
      end
      PAY_DONE: begin
        state_nx = PAY_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = PAY_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PAY_IDLE;
      rem       <= '0;
      gap_cnt   <= '0;
      sel_10    <= 1'b0;
      pay_ack   <= 1'b0;
      pay_done  <= 1'b0;
      pay_short <= 1'b0;
      pay_rem   <= '0;
      change_5  <= 1'b0;
      change_10 <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      gap_cnt   <= gap_nx;
      sel_10    <= sel_nx;
      pay_ack   <= ack_nx;
      pay_done  <= done_nx;
      pay_short <= short_nx;
      pay_rem   <= pay_rem_nx;
      change_5  <= c5_nx;
      change_10 <= c10_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: directed and random payouts against a tube-count model.
module tb_vm_change_dispenser;

  localparam int AMT_W     = 4;
  localparam int CNT_W     = 4;
  localparam int TUBE_MAX  = 15;
  localparam int INIT_5    = 4;
  localparam int INIT_10   = 4;
  localparam int PULSE_GAP = 2;
  localparam int PERIOD    = PULSE_GAP + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             coin_5_in, coin_10_in, pay_req;
  logic [AMT_W-1:0] pay_amt;
  logic             pay_ack, pay_done, pay_short, change_5, change_10, exact_only, busy;
  logic [AMT_W-1:0] pay_rem;
  logic [CNT_W-1:0] cnt_5, cnt_10;

  int checks = 0;
  int errors = 0;
  int m5, m10;

  vm_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .TUBE_MAX(TUBE_MAX),
    .INIT_5(INIT_5), .INIT_10(INIT_10), .PULSE_GAP(PULSE_GAP)
  ) dut (
    .clk(clk), .reset(reset), .coin_5_in(coin_5_in), .coin_10_in(coin_10_in),
    .pay_req(pay_req), .pay_amt(pay_amt), .pay_ack(pay_ack), .pay_done(pay_done),
    .pay_short(pay_short), .pay_rem(pay_rem), .change_5(change_5), .change_10(change_10),
    .cnt_5(cnt_5), .cnt_10(cnt_10), .exact_only(exact_only), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int c);
    return (c >= TUBE_MAX) ? TUBE_MAX : c + 1;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt5"}, 32'(cnt_5), 32'(m5));
    chk({tag, "_cnt10"}, 32'(cnt_10), 32'(m10));
    chk({tag, "_exact"}, 32'(exact_only), 32'(m5 == 0));
  endtask

  task automatic coins(input bit c5, input bit c10);
    coin_5_in  = c5;
    coin_10_in = c10;
    tick();
    coin_5_in  = 1'b0;
    coin_10_in = 1'b0;
    if (c5)  m5  = sat_add(m5);
    if (c10) m10 = sat_add(m10);
  endtask

  // Fewest coins: as many 10s as fit and are stocked, then 5s, never overpaying.
  task automatic do_pay(input int amt, input bit hold_req, input int coin10_off);
    int n10, n5, r, rem, n, done_off, p, j;
    bit pulse;
    logic [4:0] exp_v;
    logic [AMT_W-1:0] amt_v;
    n10 = (amt / 2 < m10) ? amt / 2 : m10;
    r   = amt - 2 * n10;
    n5  = (r < m5) ? r : m5;
    rem = r - n5;
    n   = n10 + n5;
    done_off = PERIOD * n + 1;
    amt_v   = AMT_W'(amt);
    pay_req = 1'b1;
    pay_amt = amt_v;
    tick();
    for (int k = 0; k <= done_off; k++) begin
      if (k > 0) tick();
      if (!hold_req || k == done_off) pay_req = 1'b0;
      coin_10_in = (k == coin10_off);
      p = k - 2;
      j = (p >= 0) ? p / PERIOD : 0;
      pulse = (p >= 0) && (p % PERIOD == 0) && (j < n);
      exp_v = {k == 0, 1'b1, pulse && j < n10, pulse && j >= n10, k == done_off};
      chk("pay_seq", 32'({pay_ack, busy, change_10, change_5, pay_done}), 32'(exp_v));
    end
    chk("pay_short", 32'(pay_short), 32'(rem != 0));
    chk("pay_rem", 32'(pay_rem), 32'(rem));
    pay_req    = 1'b0;
    coin_10_in = 1'b0;
    tick();
    chk("pay_idle", 32'({pay_ack, busy, change_10, change_5, pay_done}), 32'd0);
    m10 = m10 - n10;
    if (coin10_off >= 0) m10 = sat_add(m10);
    m5 = m5 - n5;
    chk_counts("pay_end");
  endtask

  initial begin
    reset = 1'b1; coin_5_in = 1'b0; coin_10_in = 1'b0; pay_req = 1'b0; pay_amt = '0;
    m5 = INIT_5; m10 = INIT_10;
    tick(); tick();
    chk("rst_outs", 32'({pay_ack, busy, change_10, change_5, pay_done, pay_short}), 32'd0);
    chk("rst_rem", 32'(pay_rem), 32'd0);
    chk_counts("rst");
    reset = 1'b0;
    tick();

    do_pay(3, 1'b0, -1);
    do_pay(1, 1'b1, -1);
    do_pay(6, 1'b0, -1);
    do_pay(2, 1'b0, -1);
    coins(1'b1, 1'b0);
    do_pay(3, 1'b0, -1);
    do_pay(0, 1'b0, -1);

    for (int i = 0; i < 13; i++) coins(1'b1, 1'b0);
    chk_counts("fill13");
    for (int i = 0; i < 5; i++) coins(1'b1, 1'b0);
    chk_counts("sat15");

    coins(1'b0, 1'b1);
    coins(1'b0, 1'b1);
    do_pay(2, 1'b0, 2);
    do_pay(15, 1'b0, -1);
    do_pay(4, 1'b0, -1);
    coins(1'b0, 1'b1);
    do_pay(3, 1'b0, -1);

    for (int it = 0; it < 12; it++) begin
      int nc;
      nc = $urandom_range(0, 4);
      for (int c = 0; c < nc; c++) begin
        coins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) tick();
      end
      chk_counts("rnd_coins");
      do_pay($urandom_range(0, 15), 1'($urandom_range(0, 1)), -1);
    end

    coins(1'b1, 1'b1);
    coins(1'b1, 1'b1);
    pay_req = 1'b1;
    pay_amt = 4'd3;
    tick();
    pay_req = 1'b0;
    chk("mid_ack", 32'(pay_ack), 32'd1);
    tick(); tick();
    chk("mid_pulse1", 32'({change_10, change_5}), 32'b10);
    tick();
    reset = 1'b1;
    tick();
    m5 = INIT_5; m10 = INIT_10;
    chk("mid_rst_outs", 32'({pay_ack, busy, change_10, change_5, pay_done, pay_short}), 32'd0);
    chk_counts("mid_rst");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_quiet", 32'({pay_ack, busy, change_10, change_5, pay_done}), 32'd0);
    end
    chk_counts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
